hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the five-stage MIPS datapath. It decides each cycle whether the PC, IF/ID, ID/EX and EX/MEM pipeline registers load, hold or take a bubble. The decision covers load-use hazards, taken branches resolved in MEM, and data-memory wait states. It sits beside the decode stage, reads register fields and control bits from the ID and ID/EX stages, and keeps saturating event counters for performance debug.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/sat_counter.sv | 39 +++
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the pipeline control logic.
//   action_e      - per-cycle hazard action (RUN, STALL, FLUSH, FREEZE)
//   REG_ZERO      - architectural register $zero; never a real dependency
//   CTRL_ZERO_ON  - level of a flush/bubble strobe that makes a pipeline
//                   register load all-zero control bits (a nop)
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FLUSH  = 2'd2,
        FREEZE = 2'd3
    } action_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Flush/bubble inputs on the pipeline registers are active-high.
    localparam logic CTRL_ZERO_ON  = 1'b1;
    localparam logic CTRL_ZERO_OFF = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, clears count
//   clr   - synchronous clear, wins over inc
//   inc   - count one event this cycle
//   count - current value
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;
    logic [W-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count;
        if (clr) begin
            w_count_d = '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            w_count_d = r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_d;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing control for the five-stage pipeline.
// Each cycle picks one action in priority order FREEZE > FLUSH > STALL > RUN
// and drives the load/flush strobes of PC, IF/ID, ID/EX and EX/MEM
// combinationally from it.
//   clk, rst_n              - clock, asynchronous active-low reset
//   id_rs, id_rt, id_uses_rt - source fields of the instruction in ID
//   ex_MemRead, ex_rt       - load indication and destination in ID/EX
//   mem_branch_taken        - resolved taken branch in EX/MEM
//   mem_busy                - data memory wait state
//   cnt_clr                 - synchronous clear of the event counters
//   pc_write .. exmem_flush - pipeline register controls
//   state                   - action taken in the previous cycle
//   stall_cnt, flush_cnt, freeze_cnt - saturating event counters
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch_taken,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             exmem_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    action_e r_state;
    action_e w_action;
    logic    w_hazard;

    // Load-use: the load in EX writes a register the ID instruction reads.
    always_comb begin
        w_hazard = ex_MemRead && (ex_rt != REG_ZERO) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

    // A taken branch is ignored for one cycle after a FLUSH: EX/MEM then holds
    // the bubble we inserted. During FREEZE EX/MEM holds, so the branch is
    // simply seen again once the memory is ready.
    always_comb begin
        w_action = RUN;
        if (mem_busy) begin
            w_action = FREEZE;
        end else if (mem_branch_taken && (r_state != FLUSH)) begin
            w_action = FLUSH;
        end else if (w_hazard) begin
            w_action = STALL;
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        pc_src      = 1'b0;
        ifid_write  = 1'b1;
        ifid_flush  = CTRL_ZERO_OFF;
        idex_write  = 1'b1;
        idex_bubble = CTRL_ZERO_OFF;
        exmem_write = 1'b1;
        exmem_flush = CTRL_ZERO_OFF;
        unique case (w_action)
            RUN: begin
            end
            STALL: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = CTRL_ZERO_ON;
            end
            FLUSH: begin
                pc_src      = 1'b1;
                ifid_flush  = CTRL_ZERO_ON;
                idex_bubble = CTRL_ZERO_ON;
                exmem_flush = CTRL_ZERO_ON;
            end
            FREEZE: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_write = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_action;
        end
    end

    assign state = r_state;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (w_action == STALL),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (w_action == FLUSH),
        .count (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (w_action == FREEZE),
        .count (freeze_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int unsigned CNT_W = 3;

    // {pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_bubble,
    //  exmem_write, exmem_flush}
    localparam logic [7:0] C_RUN    = 8'b1010_1010;
    localparam logic [7:0] C_STALL  = 8'b0000_1110;
    localparam logic [7:0] C_FLUSH  = 8'b1111_1111;
    localparam logic [7:0] C_FREEZE = 8'b0000_0000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_MemRead, mem_branch_taken, mem_busy, cnt_clr;
    logic             pc_write, pc_src, ifid_write, ifid_flush;
    logic             idex_write, idex_bubble, exmem_write, exmem_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;
    logic [7:0]       ctrl;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign ctrl = {pc_write, pc_src, ifid_write, ifid_flush,
                   idex_write, idex_bubble, exmem_write, exmem_flush};

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rt       (id_uses_rt),
        .ex_MemRead       (ex_MemRead),
        .ex_rt            (ex_rt),
        .mem_branch_taken (mem_branch_taken),
        .mem_busy         (mem_busy),
        .cnt_clr          (cnt_clr),
        .pc_write         (pc_write),
        .pc_src           (pc_src),
        .ifid_write       (ifid_write),
        .ifid_flush       (ifid_flush),
        .idex_write       (idex_write),
        .idex_bubble      (idex_bubble),
        .exmem_write      (exmem_write),
        .exmem_flush      (exmem_flush),
        .state            (state),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt),
        .freeze_cnt       (freeze_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_MemRead = 1'b0; ex_rt = 5'd0;
        mem_branch_taken = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic clear_counters;
        idle_inputs();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        #2;
        n_tests++;
        if (ctrl !== C_RUN) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_RUN);
        end
        n_tests++;
        if (state !== 2'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d want 0", state);
        end
        n_tests++;
        if ({stall_cnt, flush_cnt, freeze_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0",
                               stall_cnt, flush_cnt, freeze_cnt);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use;
        clear_counters();
        ex_MemRead = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        #1;
        n_tests++;
        if (ctrl !== C_STALL) begin
            n_fail++; $display("FAIL load_use_stall: got %b want %b", ctrl, C_STALL);
        end
        tick();
        ex_MemRead = 1'b0;
        #1;
        n_tests++;
        if (ctrl !== C_RUN) begin
            n_fail++; $display("FAIL load_use_after: got %b want %b", ctrl, C_RUN);
        end
        n_tests++;
        if (state !== 2'd1) begin
            n_fail++; $display("FAIL load_use_state: got %0d want 1", state);
        end
        n_tests++;
        if (stall_cnt !== 3'd1) begin
            n_fail++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt);
        end
        tick();
        n_tests++;
        if (state !== 2'd0) begin
            n_fail++; $display("FAIL load_use_back_to_run: got %0d want 0", state);
        end
        idle_inputs();
    endtask

    task automatic test_filter;
        clear_counters();
        ex_MemRead = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        n_tests++;
        if (ctrl !== C_RUN) begin
            n_fail++; $display("FAIL filter_reg0: got %b want %b", ctrl, C_RUN);
        end
        ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
        #1;
        n_tests++;
        if (ctrl !== C_RUN) begin
            n_fail++; $display("FAIL filter_rt_unused: got %b want %b", ctrl, C_RUN);
        end
        id_uses_rt = 1'b1;
        #1;
        n_tests++;
        if (ctrl !== C_STALL) begin
            n_fail++; $display("FAIL filter_rt_used: got %b want %b", ctrl, C_STALL);
        end
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if (stall_cnt !== 3'd1) begin
            n_fail++; $display("FAIL filter_cnt: got %0d want 1", stall_cnt);
        end
    endtask

    task automatic test_flush;
        clear_counters();
        mem_branch_taken = 1'b1;
        #1;
        n_tests++;
        if (ctrl !== C_FLUSH) begin
            n_fail++; $display("FAIL flush_cycle1: got %b want %b", ctrl, C_FLUSH);
        end
        tick();
        n_tests++;
        if (ctrl !== C_RUN) begin
            n_fail++; $display("FAIL flush_lockout: got %b want %b", ctrl, C_RUN);
        end
        n_tests++;
        if (state !== 2'd2) begin
            n_fail++; $display("FAIL flush_state: got %0d want 2", state);
        end
        n_tests++;
        if (flush_cnt !== 3'd1) begin
            n_fail++; $display("FAIL flush_cnt: got %0d want 1", flush_cnt);
        end
        tick();
        idle_inputs();
        n_tests++;
        if (flush_cnt !== 3'd1) begin
            n_fail++; $display("FAIL flush_cnt_after_lockout: got %0d want 1", flush_cnt);
        end
        tick();
    endtask

    task automatic test_simultaneous;
        clear_counters();
        ex_MemRead = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; mem_branch_taken = 1'b1;
        #1;
        n_tests++;
        if (ctrl !== C_FLUSH) begin
            n_fail++; $display("FAIL sim_branch_over_hazard: got %b want %b", ctrl, C_FLUSH);
        end
        tick();
        idle_inputs();
        tick();
        clear_counters();
        mem_busy = 1'b1; mem_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (ctrl !== C_FREEZE) begin
                n_fail++; $display("FAIL sim_freeze_%0d: got %b want %b", i, ctrl, C_FREEZE);
            end
            tick();
        end
        mem_busy = 1'b0;
        #1;
        n_tests++;
        if (ctrl !== C_FLUSH) begin
            n_fail++; $display("FAIL sim_deferred_flush: got %b want %b", ctrl, C_FLUSH);
        end
        n_tests++;
        if (freeze_cnt !== 3'd3) begin
            n_fail++; $display("FAIL sim_freeze_cnt: got %0d want 3", freeze_cnt);
        end
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if (flush_cnt !== 3'd1) begin
            n_fail++; $display("FAIL sim_flush_cnt: got %0d want 1", flush_cnt);
        end
        tick();
    endtask

    task automatic test_saturation;
        clear_counters();
        ex_MemRead = 1'b1; ex_rt = 5'd12; id_rt = 5'd12; id_uses_rt = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        n_tests++;
        if (stall_cnt !== 3'd7) begin
            n_fail++; $display("FAIL sat_stall_cnt: got %0d want 7", stall_cnt);
        end
        cnt_clr = 1'b1;
        #1;
        n_tests++;
        if (ctrl !== C_STALL) begin
            n_fail++; $display("FAIL sat_clr_ctrl: got %b want %b", ctrl, C_STALL);
        end
        tick();
        n_tests++;
        if (stall_cnt !== 3'd0) begin
            n_fail++; $display("FAIL sat_clr_priority: got %0d want 0", stall_cnt);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_async_reset;
        clear_counters();
        mem_busy = 1'b1; mem_branch_taken = 1'b1;
        tick();
        tick();
        n_tests++;
        if (state !== 2'd3 || freeze_cnt !== 3'd2) begin
            n_fail++; $display("FAIL areset_pre: got state %0d cnt %0d want 3/2",
                               state, freeze_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (state !== 2'd0) begin
            n_fail++; $display("FAIL areset_state: got %0d want 0", state);
        end
        n_tests++;
        if ({stall_cnt, flush_cnt, freeze_cnt} !== '0) begin
            n_fail++; $display("FAIL areset_cnt: got %0d/%0d/%0d want 0/0/0",
                               stall_cnt, flush_cnt, freeze_cnt);
        end
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (ctrl !== C_RUN || state !== 2'd0) begin
            n_fail++; $display("FAIL areset_no_deferred: got %b/%0d want %b/0",
                               ctrl, state, C_RUN);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_filter();
        test_flush();
        test_simultaneous();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
